// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and hold.
// Define ID_EX_BUBBLE_CNT_EN to add the bubble_count port and counter.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_op1,
    input  logic [XLEN-1:0]   id_op2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  bubble_count
`endif
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic clear;

    assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
    assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
    assign load_use = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0)
                    & id_valid & (rs1_hit | rs2_hit);
    assign id_stall = ~flush & (ex_hold | load_use);

    // Reset, flush and a load-use bubble all leave an empty EX slot.
    assign clear = rst | flush | (~ex_hold & load_use);

    always_ff @(posedge clk) begin
        if (clear) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= '0;
        end else if (!ex_hold) begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_op1       <= id_op1;
            ex_op2       <= id_op2;
            ex_imm       <= id_imm;
            ex_rs1_addr  <= id_rs1_addr;
            ex_rs2_addr  <= id_rs2_addr;
            ex_rd_addr   <= id_rd_addr;
            // An empty slot must not carry side-effecting control.
            ex_reg_write <= id_valid & id_reg_write;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (!flush && !ex_hold && load_use) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed + random bench for id_ex_stage_reg against a rule-level model.
module tb_id_ex_stage_reg;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              v;
        logic [XLEN-1:0]   pc, op1, op2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic              rw, mr;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [XLEN-1:0] id_pc, id_op1, id_op2, id_imm;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic flush, ex_hold;
    logic id_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_count;
`endif

    id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_ctrl(id_ctrl), .flush(flush),
        .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ex_t  m;
    int   mcnt;
    bit   known = 0;
    ex_t  dut_ex;

    assign dut_ex = '{ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1_addr,
                      ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
                      ex_ctrl};

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hazard as stated in words: a valid load in EX with rd != x0 whose
    // destination is actually read by the valid instruction in decode.
    function automatic bit hazard();
        bit reads;
        reads = (id_rs1_used && id_rs1_addr == m.rd) ||
                (id_rs2_used && id_rs2_addr == m.rd);
        return m.v && m.mr && m.rd != 0 && id_valid && reads;
    endfunction

    task automatic cycle();
        bit exp_stall;
        #1;
        exp_stall = !flush && (ex_hold || hazard());
        if (known && !rst) chk("id_stall", id_stall, exp_stall);
        @(posedge clk);
        if (rst) begin
            m = '0; mcnt = 0; known = 1;
        end else if (flush) begin
            m = '0;
        end else if (ex_hold) begin
            m = m;
        end else if (hazard()) begin
            m = '0; mcnt++;
        end else begin
            m.v = id_valid;
            m.pc = id_pc; m.op1 = id_op1; m.op2 = id_op2; m.imm = id_imm;
            m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr; m.rd = id_rd_addr;
            m.rw = id_valid ? id_reg_write : 1'b0;
            m.mr = id_valid ? id_mem_read : 1'b0;
            m.ctrl = id_valid ? id_ctrl : '0;
        end
        #1;
        chk("ex_bundle", dut_ex, m);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_count", bubble_count, mcnt % (1 << CNT_W));
`endif
    endtask

    task automatic rand_id();
        id_valid = $urandom_range(0, 3) != 0;
        id_pc = $urandom; id_op1 = $urandom; id_op2 = $urandom;
        id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
        id_rs1_addr = 5'($urandom_range(0, 3));
        id_rs2_addr = 5'($urandom_range(0, 3));
        id_rd_addr = 5'($urandom_range(0, 3));
        id_rs1_used = $urandom_range(0, 1) != 0;
        id_rs2_used = $urandom_range(0, 1) != 0;
        id_reg_write = $urandom_range(0, 1) != 0;
        id_mem_read = $urandom_range(0, 1) != 0;
    endtask

    task automatic plain(logic [4:0] rd, logic ld, logic [4:0] rs1,
                         logic u1, logic [4:0] rs2, logic u2);
        rand_id();
        id_valid = 1; id_rd_addr = rd; id_mem_read = ld;
        id_reg_write = 1; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
    endtask

    initial begin
        flush = 0; ex_hold = 0; rst = 1;
        rand_id();
        cycle();
        rand_id();
        cycle();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_pc", ex_pc, 32'h0);
        chk("rst_stall", id_stall, 1'b0);

        rst = 0;
        plain(5'd1, 0, 5'd2, 1, 5'd3, 1);
        id_pc = 32'h100; id_op1 = 32'h11;
        cycle();
        chk("rel_pc", ex_pc, 32'h100);
        chk("rel_op1", ex_op1, 32'h11);
        chk("rel_valid", ex_valid, 1'b1);

        // load x5 then dependent add
        plain(5'd5, 1, 5'd1, 1, 5'd2, 1);
        cycle();
        plain(5'd6, 0, 5'd5, 1, 5'd2, 0);
        #1 chk("lu_stall", id_stall, 1'b1);
        cycle();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_stall_off", id_stall, 1'b0);
        cycle();
        chk("lu_rs1", ex_rs1_addr, 5'd5);
        chk("lu_valid", ex_valid, 1'b1);

        // same-register double read gives one bubble
        plain(5'd9, 1, 5'd1, 1, 5'd1, 1);
        cycle();
        plain(5'd3, 0, 5'd9, 1, 5'd9, 1);
        cycle();
        cycle();
        chk("dbl_valid", ex_valid, 1'b1);

        // x0 load and unused rs2 never stall
        plain(5'd0, 1, 5'd1, 1, 5'd1, 1);
        cycle();
        plain(5'd1, 0, 5'd0, 1, 5'd0, 1);
        #1 chk("x0_stall", id_stall, 1'b0);
        cycle();
        plain(5'd7, 1, 5'd1, 1, 5'd1, 1);
        cycle();
        plain(5'd1, 0, 5'd2, 1, 5'd7, 0);
        #1 chk("unused_stall", id_stall, 1'b0);
        cycle();
        chk("unused_valid", ex_valid, 1'b1);

        // flush beats hold and load-use
        plain(5'd5, 1, 5'd1, 1, 5'd1, 1);
        cycle();
        plain(5'd2, 0, 5'd5, 1, 5'd5, 1);
        flush = 1; ex_hold = 1;
        #1 chk("fl_stall", id_stall, 1'b0);
        cycle();
        chk("fl_bundle", dut_ex, ex_t'(0));
        flush = 0; ex_hold = 0;

        // hold freezes EX
        plain(5'd1, 0, 5'd2, 1, 5'd3, 1);
        id_pc = 32'h200;
        cycle();
        for (int i = 0; i < 3; i++) begin
            ex_hold = 1;
            id_pc = 32'h300 + i;
            #1 chk("hold_stall", id_stall, 1'b1);
            cycle();
            chk("hold_pc", ex_pc, 32'h200);
        end
        ex_hold = 0; id_pc = 32'h204;
        cycle();
        chk("hold_rel_pc", ex_pc, 32'h204);

        // 17 load-use bubbles from a fresh reset
        rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < 17; i++) begin
            plain(5'd4, 1, 5'd1, 1, 5'd1, 1);
            cycle();
            plain(5'd1, 0, 5'd4, 1, 5'd1, 1);
            cycle();
            chk("wrap_bubble", ex_valid, 1'b0);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("wrap_count", bubble_count, 4'd1);
`endif

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rand_id();
            rst = $urandom_range(0, 49) == 0;
            flush = $urandom_range(0, 9) == 0;
            ex_hold = $urandom_range(0, 6) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
